serial_add_ctrl: RTL and testbench

- Sequencer for a bit-serial ripple adder.
- Accepts two WIDTH-bit parallel operands on a start handshake.
- Shifts them LSB-first through an internal one-bit full adder with a carry flop, one bit per clock.
- Reassembles the serial sum into a parallel word, then flags completion with sum, carry-out and signed-overflow results.

---
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : serial_add_ctrl                                              |
// | Brief   : Sequencer for a bit-serial ripple adder. Operands are        |
// |           shifted LSB-first through a one-bit full adder with a carry  |
// |           flop. The serial sum is reassembled into a parallel word.    |
// |           Completion is flagged together with carry-out and signed     |
// |           overflow.                                                    |
// | Options : SERIAL_ADD_CTRL_SUB_EN adds a 'sub' input for A-B.           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module serial_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
`ifdef SERIAL_ADD_CTRL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout,
   output logic             ovf
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             sum_bit;
   logic             c_next;
   logic             c_msb_in;

   // Operand B and the initial carry as loaded on an accepted start
   always_comb begin
      b_load = b_in;
      c_load = cin;
`ifdef SERIAL_ADD_CTRL_SUB_EN
      if (sub) begin
         b_load = ~b_in;
         c_load = 1'b1;
      end
`endif
   end

   // One-bit full adder on the current LSBs; during the last bit the
   // carry flop holds the carry into the MSB.
   always_comb begin
      sum_bit  = a_sr[0] ^ b_sr[0] ^ carry;
      c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      c_msb_in = carry;
   end

   // Sequencer state, datapath shift registers and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum_out <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sr    <= a_in;
                  b_sr    <= b_load;
                  carry   <= c_load;
                  cnt     <= '0;
                  sum_out <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sum_out <= {sum_bit, sum_out[WIDTH-1:1]};
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               carry   <= c_next;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  cout  <= c_next;
                  ovf   <= c_msb_in ^ c_next;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Status flags decoded straight from the state register
   always_comb begin
      busy = (state == ST_SHIFT);
      done = (state == ST_DONE);
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_serial_add_ctrl                                           |
// | Brief   : Self-checking bench for serial_add_ctrl (WIDTH=8).           |
// |           Builds with or without SERIAL_ADD_CTRL_SUB_EN.               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout;
   logic         ovf;
`ifdef SERIAL_ADD_CTRL_SUB_EN
   logic         sub;
   logic         sub_v;
`endif

   serial_add_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .cin     (cin),
`ifdef SERIAL_ADD_CTRL_SUB_EN
      .sub     (sub),
`endif
      .busy    (busy),
      .done    (done),
      .sum_out (sum_out),
      .cout    (cout),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Drive one operation, push its expectation, then wait for done and compare
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic eco, input logic eov);
      exp_t e;
      int   n;
      int   busy_cnt;
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      cin   = c;
`ifdef SERIAL_ADD_CTRL_SUB_EN
      sub   = sub_v;
`endif
      start = 1'b1;
      e.s = es; e.co = eco; e.ov = eov;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a_in  = ~a;
      b_in  = ~b;
      cin   = ~c;
      n = 0;
      busy_cnt = 0;
      while (!done && n < 50) begin
         if (busy) busy_cnt++;
         n++;
         @(negedge clk);
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL op_timeout: got no done expected done within 50 cycles");
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         check("busy_cycles", busy_cnt, W);
         check("sum_out", sum_out, e.s);
         check("cout", cout, e.co);
         check("ovf", ovf, e.ov);
         check("busy_in_done", busy, 0);
      end
   endtask

   initial begin
      int t_done[3];
      int nd;
      int cyc;

      vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0};
      vecs[7] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0};

      reset = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      cin   = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
      sub   = 1'b0;
      sub_v = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum_out, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, vecs[i].ov);

      // Start during SHIFT must be ignored and not queued
      @(negedge clk);
      a_in = 8'h11; b_in = 8'h22; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nd = 0;
      for (int k = 0; k < 2 * W + 6; k++) begin
         if (done) begin
            nd++;
            check("ign_sum", sum_out, 8'h33);
         end
         @(negedge clk);
      end
      check("ign_done_count", nd, 1);

      // Start held high: one operation every WIDTH+2 cycles
      a_in = 8'h01; b_in = 8'h02; cin = 1'b0; start = 1'b1;
      nd = 0;
      cyc = 0;
      while (nd < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            t_done[nd] = cyc;
            nd++;
            check("held_sum", sum_out, 8'h03);
         end
      end
      start = 1'b0;
      if (nd < 3) begin
         compared++;
         mismatched++;
         $display("FAIL held_timeout: got %0d done pulses expected 3", nd);
      end else begin
         check("held_period_1", t_done[1] - t_done[0], W + 2);
         check("held_period_2", t_done[2] - t_done[1], W + 2);
      end
      repeat (2) @(negedge clk);

      // Asynchronous reset mid-operation aborts it with no done pulse
      do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      @(negedge clk);
      a_in = 8'h80; b_in = 8'h80; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_sum", sum_out, 0);
      check("arst_cout", cout, 0);
      check("arst_ovf", ovf, 0);
      @(negedge clk);
      reset = 1'b1;
      nd = 0;
      for (int k = 0; k < 2 * W; k++) begin
         if (done || busy) nd++;
         @(negedge clk);
      end
      check("arst_no_resume", nd, 0);
      do_op(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);

`ifdef SERIAL_ADD_CTRL_SUB_EN
      sub_v = 1'b1;
      do_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
      sub_v = 1'b0;
`endif

      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
